// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 16-bit ALU: request FIFO, head drive onto the ALU inputs,
// registered result with valid/ready, accumulator chaining and a sticky overflow flag.
module alu_issue_stage #(
  parameter int data_width = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_func,
  input  logic [data_width-1:0]   in_a,
  input  logic [data_width-1:0]   in_b,
  input  logic                    in_use_acc,
  output logic [3:0]              alu_func,
  output logic [data_width-1:0]   alu_a,
  output logic [data_width-1:0]   alu_b,
  input  logic [data_width-1:0]   alu_c,
  input  logic                    alu_overflow,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [data_width-1:0]   out_c,
  output logic                    out_overflow,
  output logic                    overflow_sticky,
  input  logic                    clear_sticky,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int ptrWidth = $clog2(DEPTH);
  localparam int cntWidth = ptrWidth + 1;

  localparam logic [3:0] FUNC_ZERO = 4'h0;

  typedef struct packed {
    logic [3:0]            func;
    logic [data_width-1:0] a;
    logic [data_width-1:0] b;
    logic                  useAcc;
  } entryT;

  entryT                 entries [DEPTH];
  entryT                 headEntry;
  logic [ptrWidth-1:0]   wrPtr;
  logic [ptrWidth-1:0]   rdPtr;
  logic [data_width-1:0] acc;
  logic                  push;
  logic                  cap;
  logic                  notEmpty;

  assign notEmpty  = (count != '0);
  assign in_ready  = (count < cntWidth'(DEPTH));
  assign push      = in_valid && in_ready;
  assign cap       = notEmpty && (!out_valid || out_ready);
  assign headEntry = entries[rdPtr];

  // Accumulator substitution happens here, so a chained request sees the result captured on the previous edge.
  always_comb begin
    alu_func = FUNC_ZERO;
    alu_a    = '0;
    alu_b    = '0;
    if (notEmpty) begin
      alu_func = headEntry.func;
      alu_b    = headEntry.b;
      alu_a    = headEntry.useAcc ? acc : headEntry.a;
    end
  end

  // Storage carries no reset; occupancy is governed solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wrPtr] <= '{func: in_func, a: in_a, b: in_b, useAcc: in_use_acc};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + ptrWidth'(1);
      if (cap)  rdPtr <= rdPtr + ptrWidth'(1);
      case ({push, cap})
        2'b10:   count <= count + cntWidth'(1);
        2'b01:   count <= count - cntWidth'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid       <= 1'b0;
      out_c           <= '0;
      out_overflow    <= 1'b0;
      acc             <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      if (cap) begin
        out_valid    <= 1'b1;
        out_c        <= alu_c;
        out_overflow <= alu_overflow;
        acc          <= alu_c;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A new overflow takes priority over a same-cycle clear.
      if (cap && alu_overflow) begin
        overflow_sticky <= 1'b1;
      end else if (clear_sticky) begin
        overflow_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU on the alu_* ports.
module tb_alu_issue_stage;

  localparam logic [3:0] FUNC_ZERO = 4'h0;
  localparam logic [3:0] FUNC_ADD  = 4'h1;
  localparam logic [3:0] FUNC_SUB  = 4'h2;
  localparam logic [3:0] FUNC_XOR  = 4'h5;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_use_acc;
  logic [3:0]  alu_func;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_c;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_c;
  logic        out_overflow;
  logic        overflow_sticky;
  logic        clear_sticky;
  logic [2:0]  count;

  int compared = 0;
  int mismatched = 0;

  alu_issue_stage #(.data_width(16), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_overflow(out_overflow), .overflow_sticky(overflow_sticky),
    .clear_sticky(clear_sticky), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: signed overflow only on add/subtract.
  always_comb begin
    alu_c        = 16'h0000;
    alu_overflow = 1'b0;
    case (alu_func)
      FUNC_ADD: begin
        alu_c        = alu_a + alu_b;
        alu_overflow = (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]);
      end
      FUNC_SUB: begin
        alu_c        = alu_a - alu_b;
        alu_overflow = (alu_a[15] != alu_b[15]) && (alu_c[15] != alu_a[15]);
      end
      FUNC_XOR: alu_c = alu_a ^ alu_b;
      default:  alu_c = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic ua);
    in_valid   = v;
    in_func    = f;
    in_a       = a;
    in_b       = b;
    in_use_acc = ua;
  endtask

  initial begin
    reset_n = 1'b0;
    out_ready = 1'b0;
    clear_sticky = 1'b0;
    drive(1'b0, FUNC_ZERO, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_c", out_c, 0);
    check("rst_out_overflow", out_overflow, 0);
    check("rst_sticky", overflow_sticky, 0);
    check("rst_alu_func", alu_func, FUNC_ZERO);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single overflowing ADD
    drive(1'b1, FUNC_ADD, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    drive(1'b0, FUNC_ZERO, 16'h0, 16'h0, 1'b0);
    check("add_count_after_push", count, 1);
    check("add_not_yet_valid", out_valid, 0);
    check("add_head_alu_a", alu_a, 16'h7FFF);
    @(negedge clk);
    check("add_out_valid", out_valid, 1);
    check("add_out_c", out_c, 16'h8000);
    check("add_out_overflow", out_overflow, 1);
    check("add_sticky", overflow_sticky, 1);
    check("add_count_after_pop", count, 0);
    out_ready = 1'b1;
    clear_sticky = 1'b1;
    @(negedge clk);
    clear_sticky = 1'b0;
    check("add_drained", out_valid, 0);
    check("sticky_cleared", overflow_sticky, 0);
    check("empty_acc_kept_out_c", out_c, 16'h8000);

    // Accumulator chain: 3+4, then acc-2
    drive(1'b1, FUNC_ADD, 16'h0003, 16'h0004, 1'b0);
    @(negedge clk);
    drive(1'b1, FUNC_SUB, 16'h1234, 16'h0002, 1'b1);
    @(negedge clk);
    drive(1'b0, FUNC_ZERO, 16'h0, 16'h0, 1'b0);
    check("chain1_valid", out_valid, 1);
    check("chain1_c", out_c, 16'h0007);
    check("chain1_ovf", out_overflow, 0);
    check("chain2_alu_a_is_acc", alu_a, 16'h0007);
    @(negedge clk);
    check("chain2_valid", out_valid, 1);
    check("chain2_c", out_c, 16'h0005);
    check("chain2_ovf", out_overflow, 0);
    @(negedge clk);
    check("chain_drained", out_valid, 0);

    // Backpressure: five pushes with the consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, FUNC_ADD, 16'(i), 16'h0100, 1'b0);
      @(negedge clk);
    end
    check("bp_count_full", count, 4);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_c_first", out_c, 16'h0101);
    drive(1'b1, FUNC_ADD, 16'h0006, 16'h0100, 1'b0);
    @(negedge clk);
    check("bp_refused_count", count, 4);
    check("bp_out_c_stable", out_c, 16'h0101);
    check("bp_out_valid_held", out_valid, 1);
    drive(1'b0, FUNC_ZERO, 16'h0, 16'h0, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp_result%0d", k + 2), out_c, 32'h0102 + 32'(k));
      check($sformatf("bp_valid%0d", k + 2), out_valid, 1);
    end
    check("bp_count_empty", count, 0);
    @(negedge clk);
    check("bp_drained", out_valid, 0);

    // Same-cycle clear and overflow capture: set wins
    drive(1'b1, FUNC_SUB, 16'h8000, 16'h0001, 1'b0);
    @(negedge clk);
    drive(1'b0, FUNC_ZERO, 16'h0, 16'h0, 1'b0);
    clear_sticky = 1'b1;
    @(negedge clk);
    check("sub_out_c", out_c, 16'h7FFF);
    check("sub_out_overflow", out_overflow, 1);
    check("sticky_set_wins", overflow_sticky, 1);
    @(negedge clk);
    clear_sticky = 1'b0;
    check("sticky_clear_alone", overflow_sticky, 0);

    // Wrap-around: twelve back-to-back XORs
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, FUNC_XOR, 16'(i), 16'h00FF, 1'b0);
      @(negedge clk);
      check($sformatf("wrap_count%0d", i), count, 1);
      if (i >= 1) check($sformatf("wrap_c%0d", i - 1), out_c, 32'(i - 1) ^ 32'h00FF);
    end
    drive(1'b0, FUNC_ZERO, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    check("wrap_c11", out_c, 32'h00F4);
    check("wrap_ovf", out_overflow, 0);
    check("wrap_count_end", count, 0);
    @(negedge clk);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, FUNC_ADD, 16'(i * 16), 16'h0020, 1'b0);
      @(negedge clk);
    end
    drive(1'b0, FUNC_ZERO, 16'h0, 16'h0, 1'b0);
    check("pre_rst_count", count, 3);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_c", out_c, 16'h0030);
    #2 reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", out_valid, 0);
    check("arst_out_c", out_c, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_alu_a", alu_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, FUNC_ADD, 16'h5555, 16'h0003, 1'b1);
    @(negedge clk);
    drive(1'b0, FUNC_ZERO, 16'h0, 16'h0, 1'b0);
    check("post_rst_count", count, 1);
    check("post_rst_acc_a", alu_a, 0);
    @(negedge clk);
    check("post_rst_c", out_c, 16'h0003);
    check("post_rst_valid", out_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
